// File: rtl/lsu_rv32_pkg.sv
// lsu_rv32_pkg: shared definitions for the load/store unit.
//   - RV32I funct3 width codes used on the request side
//   - FSM state encoding
//   - store byte-lane mask and lane-replicated write data helpers
package lsu_rv32_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [2:0] {
        IDLE,
        ST_ISSUE,
        LD_ISSUE,
        LD_WAIT,
        DONE
    } state_t;

    function automatic logic [3:0] wmask_for(input logic [2:0] funct3,
                                             input logic [1:0] addr_lo);
        case (funct3)
            F3_B:    wmask_for = 4'b0001 << addr_lo;
            F3_H:    wmask_for = addr_lo[1] ? 4'b1100 : 4'b0011;
            F3_W:    wmask_for = 4'b1111;
            default: wmask_for = 4'b0000;
        endcase
    endfunction

    // Store data is replicated across lanes so the mask alone selects bytes.
    function automatic logic [31:0] wdata_for(input logic [2:0]  funct3,
                                              input logic [31:0] wdata);
        case (funct3)
            F3_B:    wdata_for = {4{wdata[7:0]}};
            F3_H:    wdata_for = {2{wdata[15:0]}};
            default: wdata_for = wdata;
        endcase
    endfunction

endpackage

// File: rtl/lsu_load_align.sv
// lsu_load_align: extracts the addressed byte/halfword from a memory word
// and sign- or zero-extends it according to the load width code.
//   word    in  32  memory read word
//   addr_lo in  2   low byte-address bits of the load
//   funct3  in  3   load width code (LB/LH/LW/LBU/LHU)
//   result  out 32  aligned, extended load result (0 for other codes)
module lsu_load_align
    import lsu_rv32_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  addr_lo,
    input  logic [2:0]  funct3,
    output logic [31:0] result
);

    logic [7:0]  lb;
    logic [15:0] lh;

    always_comb begin
        lb = word[{addr_lo, 3'b000} +: 8];
        lh = addr_lo[1] ? word[31:16] : word[15:0];
        case (funct3)
            F3_B:    result = {{24{lb[7]}}, lb};
            F3_H:    result = {{16{lh[15]}}, lh};
            F3_W:    result = word;
            F3_BU:   result = {24'h0, lb};
            F3_HU:   result = {16'h0, lh};
            default: result = '0;
        endcase
    end

endmodule

// File: rtl/lsu_rv32.sv
// lsu_rv32: load/store unit, initiator side of the word-addressed memory bus.
// One request at a time; every output is registered.
//   clk, reset              clock, async active-high reset
//   req_valid/req_ready     request handshake
//   req_we/funct3/addr/wdata request fields (store = req_we)
//   rsp_valid/rdata/err     one-cycle completion pulse with load data / error
//   mem_addr/wdata/wmask    word address, replicated store data, lane enables
//   mem_rstrb               one-cycle read strobe
//   mem_rdata/mem_rbusy     read word and not-yet-valid flag from memory
// Build option: LSU_MISALIGN_TRAP_EN turns misaligned H/W accesses into
// errors with no bus access; otherwise the misaligned low bits are ignored.
//
// state    | meaning
// IDLE     | ready for a request, bus quiet
// ST_ISSUE | write mask/data on the bus for one cycle
// LD_ISSUE | read strobe on the bus for one cycle
// LD_WAIT  | waiting for mem_rbusy to drop, then capture data
// DONE     | rsp_valid pulse
module lsu_rv32
    import lsu_rv32_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [2:0]        req_funct3,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              rsp_valid,
    output logic [31:0]       rsp_rdata,
    output logic              rsp_err,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic [3:0]        mem_wmask,
    output logic              mem_rstrb,
    input  logic [31:0]       mem_rdata,
    input  logic              mem_rbusy
);

    state_t            state, state_nx;
    logic [2:0]        f3_q, f3_nx;
    logic [1:0]        alo_q, alo_nx;
    logic              req_ready_nx, rsp_valid_nx, rsp_err_nx, mem_rstrb_nx;
    logic [31:0]       rsp_rdata_nx, mem_wdata_nx, ld_data;
    logic [3:0]        mem_wmask_nx;
    logic [ADDR_W-1:0] mem_addr_nx;
    logic              legal, misalign;

    lsu_load_align u_align (
        .word    (mem_rdata),
        .addr_lo (alo_q),
        .funct3  (f3_q),
        .result  (ld_data)
    );

    assign legal = req_we ? (req_funct3 <= F3_W)
                          : (req_funct3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU});

`ifdef LSU_MISALIGN_TRAP_EN
    assign misalign = (req_funct3[1:0] == 2'b01 && req_addr[0])
                   || (req_funct3[1:0] == 2'b10 && req_addr[1:0] != 2'b00);
`else
    assign misalign = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            f3_q      <= '0;
            alo_q     <= '0;
            req_ready <= 1'b1;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_wmask <= '0;
            mem_rstrb <= 1'b0;
        end else begin
            state     <= state_nx;
            f3_q      <= f3_nx;
            alo_q     <= alo_nx;
            req_ready <= req_ready_nx;
            rsp_valid <= rsp_valid_nx;
            rsp_rdata <= rsp_rdata_nx;
            rsp_err   <= rsp_err_nx;
            mem_addr  <= mem_addr_nx;
            mem_wdata <= mem_wdata_nx;
            mem_wmask <= mem_wmask_nx;
            mem_rstrb <= mem_rstrb_nx;
        end
    end

    // Outputs are computed for the state being entered, so they line up
    // with that state once registered.
    always_comb begin
        state_nx     = state;
        f3_nx        = f3_q;
        alo_nx       = alo_q;
        req_ready_nx = 1'b0;
        rsp_valid_nx = 1'b0;
        rsp_rdata_nx = '0;
        rsp_err_nx   = 1'b0;
        mem_addr_nx  = mem_addr;
        mem_wdata_nx = '0;
        mem_wmask_nx = '0;
        mem_rstrb_nx = 1'b0;
        case (state)
            IDLE: begin
                req_ready_nx = 1'b1;
                mem_addr_nx  = '0;
                if (req_valid) begin
                    req_ready_nx = 1'b0;
                    f3_nx        = req_funct3;
                    alo_nx       = req_addr[1:0];
                    if (!legal || misalign) begin
                        state_nx     = DONE;
                        rsp_valid_nx = 1'b1;
                        rsp_err_nx   = 1'b1;
                    end else if (req_we) begin
                        state_nx     = ST_ISSUE;
                        mem_addr_nx  = {req_addr[ADDR_W-1:2], 2'b00};
                        mem_wmask_nx = wmask_for(req_funct3, req_addr[1:0]);
                        mem_wdata_nx = wdata_for(req_funct3, req_wdata);
                    end else begin
                        state_nx     = LD_ISSUE;
                        mem_addr_nx  = {req_addr[ADDR_W-1:2], 2'b00};
                        mem_rstrb_nx = 1'b1;
                    end
                end
            end
            ST_ISSUE: begin
                state_nx     = DONE;
                rsp_valid_nx = 1'b1;
            end
            LD_ISSUE: begin
                state_nx = LD_WAIT;
            end
            LD_WAIT: begin
                if (!mem_rbusy) begin
                    state_nx     = DONE;
                    rsp_valid_nx = 1'b1;
                    rsp_rdata_nx = ld_data;
                end
            end
            DONE: begin
                state_nx     = IDLE;
                req_ready_nx = 1'b1;
                mem_addr_nx  = '0;
            end
            default: begin
                state_nx     = IDLE;
                req_ready_nx = 1'b1;
                mem_addr_nx  = '0;
            end
        endcase
    end

endmodule

// File: tb/tb_lsu_rv32.sv
`timescale 1ns/1ps
module tb_lsu_rv32;
    import lsu_rv32_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid, req_ready, req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr, req_wdata;
    logic        rsp_valid, rsp_err;
    logic [31:0] rsp_rdata, mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_wmask;
    logic        mem_rstrb, mem_rbusy;

    always #5 clk = ~clk;

    lsu_rv32 #(.ADDR_W(32)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
        .mem_rstrb(mem_rstrb), .mem_rdata(mem_rdata), .mem_rbusy(mem_rbusy)
    );

    typedef struct packed {
        logic        rdy;
        logic        vld;
        logic        err;
        logic        rstrb;
        logic [3:0]  wmask;
        logic [31:0] rdata;
        logic [31:0] addr;
        logic [31:0] wdata;
    } ovec_t;

    ovec_t       exp_q[$];
    int          tests = 0, fails = 0;
    logic [7:0]  ref_mem [64];
    logic [31:0] bus_mem [16];
    int          busy_n = 0, bus_cnt;
    logic [31:0] bus_pend;
    bit          mon_en = 0;
    int          cyc, rstrb_cnt, obs_lat;
    logic [31:0] obs_rdata, obs_wdata, obs_addr;
    logic [3:0]  obs_wmask;
    logic        obs_err;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- memory bus model ----------------
    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                          input logic [3:0] m);
        logic [31:0] r;
        r = old;
        for (int i = 0; i < 4; i++)
            if (m[i]) r[8*i +: 8] = d[8*i +: 8];
        return r;
    endfunction

    assign mem_rbusy = (bus_cnt != 0);

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            bus_cnt   <= 0;
            mem_rdata <= '0;
            bus_pend  <= '0;
        end else begin
            if (mem_wmask != 4'b0000)
                bus_mem[mem_addr[5:2]] <= merge(bus_mem[mem_addr[5:2]], mem_wdata, mem_wmask);
            if (mem_rstrb) begin
                bus_pend <= mem_addr;
                if (busy_n == 0) begin
                    mem_rdata <= bus_mem[mem_addr[5:2]];
                    bus_cnt   <= 0;
                end else begin
                    mem_rdata <= $urandom;
                    bus_cnt   <= busy_n;
                end
            end else if (bus_cnt > 1) begin
                bus_cnt   <= bus_cnt - 1;
                mem_rdata <= $urandom;
            end else if (bus_cnt == 1) begin
                bus_cnt   <= 0;
                mem_rdata <= bus_mem[bus_pend[5:2]];
            end else begin
                mem_rdata <= $urandom;
            end
        end
    end

    // ---------------- reference model ----------------
    function automatic int size_of(input logic [2:0] f3);
        return 1 << (int'(f3) % 4);
    endfunction

    function automatic logic [31:0] model_ld(input logic [2:0] f3, input logic [31:0] addr);
        int size, off, base;
        logic [31:0] val;
        size = size_of(f3);
        off  = ((int'(addr % 4)) / size) * size;
        base = int'((addr - addr % 4) % 64);
        val  = 0;
        for (int k = 0; k < size; k++)
            val |= {24'h0, ref_mem[base + off + k]} << (8 * k);
        if (int'(f3) < 4 && size < 4 && val[8*size-1])
            val |= 32'hFFFF_FFFF << (8 * size);
        return val;
    endfunction

    task automatic do_req(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] wd, input int busy);
        int f, size, off, base, len;
        bit err;
        logic [31:0] waddr, wdr;
        logic [3:0] m;
        ovec_t v;
        f    = int'(f3);
        err  = we ? (f > 2) : !(f == 0 || f == 1 || f == 2 || f == 4 || f == 5);
        size = size_of(f3);
`ifdef LSU_MISALIGN_TRAP_EN
        if (!err && (addr % size) != 0) err = 1;
`endif
        off   = ((int'(addr % 4)) / size) * size;
        waddr = addr - addr % 4;
        base  = int'(waddr % 64);
        @(negedge clk);
        v = '0;
        if (err) begin
            v.vld = 1'b1;
            v.err = 1'b1;
            exp_q.push_back(v);
            len = 1;
        end else if (we) begin
            m = '0;
            wdr = '0;
            for (int i = 0; i < 4; i++) begin
                wdr[8*i +: 8] = wd[8*(i % size) +: 8];
                if (i >= off && i < off + size) begin
                    m[i] = 1'b1;
                    ref_mem[base + i] = wd[8*(i - off) +: 8];
                end
            end
            v.addr = waddr; v.wmask = m; v.wdata = wdr;
            exp_q.push_back(v);
            v = '0;
            v.addr = waddr; v.vld = 1'b1;
            exp_q.push_back(v);
            len = 2;
        end else begin
            v.addr = waddr; v.rstrb = 1'b1;
            exp_q.push_back(v);
            v.rstrb = 1'b0;
            repeat (busy + 1) exp_q.push_back(v);
            v.vld = 1'b1; v.rdata = model_ld(f3, addr);
            exp_q.push_back(v);
            len = busy + 3;
        end
        busy_n = busy;
        cyc = 0; rstrb_cnt = 0; obs_lat = -1;
        obs_rdata = 'x; obs_err = 'x; obs_wmask = 'x; obs_wdata = 'x; obs_addr = 'x;
        req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wd;
        @(negedge clk);
        req_valid = 1'b0; req_addr = $urandom; req_wdata = $urandom;
        repeat (len) @(negedge clk);
    endtask

    // ---------------- per-cycle compare ----------------
    task automatic mon_step();
        ovec_t e;
        cyc++;
        if (exp_q.size() != 0) e = exp_q.pop_front();
        else begin
            e = '0;
            e.rdy = 1'b1;
        end
        chk("req_ready", {31'h0, req_ready}, {31'h0, e.rdy});
        chk("rsp_valid", {31'h0, rsp_valid}, {31'h0, e.vld});
        chk("rsp_err",   {31'h0, rsp_err},   {31'h0, e.err});
        chk("mem_rstrb", {31'h0, mem_rstrb}, {31'h0, e.rstrb});
        chk("mem_wmask", {28'h0, mem_wmask}, {28'h0, e.wmask});
        chk("rsp_rdata", rsp_rdata, e.rdata);
        chk("mem_addr",  mem_addr,  e.addr);
        chk("mem_wdata", mem_wdata, e.wdata);
        if (mem_rstrb) rstrb_cnt++;
        if (mem_wmask != 4'b0000) begin
            obs_wmask = mem_wmask; obs_wdata = mem_wdata; obs_addr = mem_addr;
        end
        if (rsp_valid) begin
            obs_rdata = rsp_rdata; obs_err = rsp_err; obs_lat = cyc;
        end
    endtask

    always @(posedge clk) begin
        #1;
        if (mon_en) mon_step();
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    logic [2:0]  d_f3  [5] = '{F3_B, F3_BU, F3_H, F3_HU, F3_W};
    logic [31:0] d_adr [5] = '{32'h13, 32'h13, 32'h12, 32'h12, 32'h10};
    logic [31:0] d_exp [5] = '{32'hFFFF_FF80, 32'h0000_0080, 32'hFFFF_80FF,
                               32'h0000_80FF, 32'h80FF_1234};
    logic [2:0]  ld_ok [5] = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};

    initial begin
        logic [31:0] prev;
        logic        we;
        logic [2:0]  f3;
        reset = 1'b1;
        req_valid = 1'b0; req_we = 1'b0; req_funct3 = '0; req_addr = '0; req_wdata = '0;
        #1;
        chk("reset req_ready", {31'h0, req_ready}, 32'h1);
        chk("reset rsp_valid", {31'h0, rsp_valid}, 32'h0);
        chk("reset mem_wmask", {28'h0, mem_wmask}, 32'h0);
        chk("reset mem_rstrb", {31'h0, mem_rstrb}, 32'h0);
        chk("reset mem_addr",  mem_addr, 32'h0);
        repeat (3) @(negedge clk);
        reset = 1'b0;
        mon_en = 1'b1;

        for (int i = 0; i < 16; i++) do_req(1'b1, F3_W, i * 4, $urandom, 0);

        do_req(1'b1, F3_W, 32'h10, 32'hDEAD_BEEF, 0);
        chk("SW wmask", {28'h0, obs_wmask}, 32'hF);
        chk("SW addr",  obs_addr, 32'h10);
        chk("SW wdata", obs_wdata, 32'hDEAD_BEEF);
        chk("SW latency", obs_lat, 2);
        chk("SW err", {31'h0, obs_err}, 32'h0);
        do_req(1'b1, F3_B, 32'h13, 32'h0000_00A5, 0);
        chk("SB wmask", {28'h0, obs_wmask}, 32'h8);
        chk("SB wdata", obs_wdata, 32'hA5A5_A5A5);
        do_req(1'b1, F3_H, 32'h12, 32'h0000_1234, 0);
        chk("SH wmask", {28'h0, obs_wmask}, 32'hC);
        chk("SH wdata", obs_wdata, 32'h1234_1234);
        do_req(1'b1, F3_W, 32'h10, 32'h80FF_1234, 0);
        for (int i = 0; i < 5; i++) begin
            chk("model load", model_ld(d_f3[i], d_adr[i]), d_exp[i]);
            do_req(1'b0, d_f3[i], d_adr[i], 0, 0);
            chk("load rdata", obs_rdata, d_exp[i]);
            chk("load latency", obs_lat, 3);
        end
        do_req(1'b0, F3_W, 32'h10, 0, 3);
        chk("busy latency", obs_lat, 6);
        chk("busy rstrb count", rstrb_cnt, 1);
        chk("busy rdata", obs_rdata, 32'h80FF_1234);
        do_req(1'b0, 3'b011, 32'h10, 0, 0);
        chk("bad f3 err", {31'h0, obs_err}, 32'h1);
        chk("bad f3 rdata", obs_rdata, 32'h0);
        chk("bad f3 rstrb count", rstrb_cnt, 0);
        do_req(1'b1, F3_W, 32'h0, 32'hCAFE_0001, 0);
        do_req(1'b0, F3_W, 32'h2, 0, 0);
`ifdef LSU_MISALIGN_TRAP_EN
        chk("LW 0x02 err", {31'h0, obs_err}, 32'h1);
        chk("LW 0x02 rstrb count", rstrb_cnt, 0);
        chk("LW 0x02 rdata", obs_rdata, 32'h0);
`else
        chk("LW 0x02 err", {31'h0, obs_err}, 32'h0);
        chk("LW 0x02 rdata", obs_rdata, 32'hCAFE_0001);
`endif

        // Reset while a load waits on mem_rbusy.
        @(negedge clk);
        mon_en = 1'b0;
        busy_n = 6;
        req_valid = 1'b1; req_we = 1'b0; req_funct3 = F3_W; req_addr = 32'h10;
        @(negedge clk);
        req_valid = 1'b0;
        chk("abort ld rstrb issued", {31'h0, mem_rstrb}, 32'h1);
        @(negedge clk);
        chk("abort ld waiting", {31'h0, rsp_valid | mem_rstrb}, 32'h0);
        reset = 1'b1;
        #1;
        chk("abort ld ready", {31'h0, req_ready}, 32'h1);
        chk("abort ld rstrb", {31'h0, mem_rstrb}, 32'h0);
        chk("abort ld wmask", {28'h0, mem_wmask}, 32'h0);
        chk("abort ld rsp_valid", {31'h0, rsp_valid}, 32'h0);
        @(negedge clk);
        reset = 1'b0;
        exp_q.delete();
        mon_en = 1'b1;
        do_req(1'b0, F3_W, 32'h10, 0, 0);
        chk("after abort ld rdata", obs_rdata, 32'h80FF_1234);

        // Reset while a store is on the bus: the write must not land.
        prev = model_ld(F3_W, 32'h20);
        @(negedge clk);
        mon_en = 1'b0;
        req_valid = 1'b1; req_we = 1'b1; req_funct3 = F3_W; req_addr = 32'h20;
        req_wdata = ~prev;
        @(negedge clk);
        req_valid = 1'b0;
        chk("abort st wmask issued", {28'h0, mem_wmask}, 32'hF);
        reset = 1'b1;
        #1;
        chk("abort st wmask", {28'h0, mem_wmask}, 32'h0);
        chk("abort st rstrb", {31'h0, mem_rstrb}, 32'h0);
        chk("abort st rsp_valid", {31'h0, rsp_valid}, 32'h0);
        chk("abort st ready", {31'h0, req_ready}, 32'h1);
        @(negedge clk);
        reset = 1'b0;
        exp_q.delete();
        mon_en = 1'b1;
        do_req(1'b0, F3_W, 32'h20, 0, 0);
        chk("after abort st word", obs_rdata, prev);

        for (int n = 0; n < 200; n++) begin
            we = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 9) == 0) f3 = 3'($urandom);
            else if (we) f3 = 3'($urandom_range(0, 2));
            else f3 = ld_ok[$urandom_range(0, 4)];
            do_req(we, f3, ($urandom & 32'hFFFF_FFC0) | $urandom_range(0, 63), $urandom,
                   ($urandom_range(0, 7) == 0) ? $urandom_range(4, 8) : $urandom_range(0, 3));
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        repeat (3) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
